// File: rtl/nios2_oci_dct_pkg.sv
// nios2_oci_dct_pkg: shared state encoding and entry-width constants for the DCT capture buffer
package nios2_oci_dct_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, ENDED} state_e;
    localparam int DEF_DATA_W = 30;
    localparam int DEF_CNT_W = 4;
    localparam int ENTRY_W = DEF_CNT_W + DEF_DATA_W;
    function automatic int entry_width(input int cnt_w, input int data_w);
        return cnt_w + data_w;
    endfunction
endpackage

// File: rtl/nios2_oci_dct_ram.sv
// nios2_oci_dct_ram: DEPTH x W storage, one synchronous write port, one asynchronous read port
module nios2_oci_dct_ram #(
    parameter int W = 34,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/nios2_oci_dct_capture.sv
// nios2_oci_dct_capture: trace capture FIFO with flush sequencing; NIOS2_OCI_DCT_WRAP_EN overwrites oldest when full
import nios2_oci_dct_pkg::*;
module nios2_oci_dct_capture #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int DEPTH = 16,
    localparam int EW = entry_width(CNT_W, DATA_W),
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              dct_valid,
    input  logic [DATA_W-1:0] dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              test_ending,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [EW-1:0]     rd_data,
    output logic [LW-1:0]     level,
    output logic [15:0]       drop_cnt,
    output logic              test_has_ended
);
    state_e state_q, state_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [15:0] drop_q, drop_d;
    logic wr_req, pop, full, drop, ovw, wr_en, arm_ok;
    assign rd_valid = level_q != '0;
    assign pop = rd_valid && rd_ready;
    assign full = level_q == LW'(DEPTH);
    assign wr_req = state_q == CAPTURE && dct_valid && dct_count != '0;
    assign drop = wr_req && full && !pop;
`ifdef NIOS2_OCI_DCT_WRAP_EN
    assign ovw = drop;
    assign wr_en = wr_req;
`else
    assign ovw = 1'b0;
    assign wr_en = wr_req && !drop;
`endif
    assign arm_ok = arm && !test_ending && (state_q == IDLE || state_q == ENDED);
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = test_ending ? (level_q == '0 ? ENDED : FLUSH) : arm ? CAPTURE : IDLE;
            CAPTURE: state_d = test_ending ? FLUSH : CAPTURE;
            FLUSH:   state_d = level_q == '0 ? ENDED : FLUSH;
            ENDED:   state_d = arm_ok ? CAPTURE : ENDED;
            default: state_d = IDLE;
        endcase
        // an overwrite replaces the oldest entry, so occupancy does not grow
        level_d = level_q + LW'(wr_en && !ovw) - LW'(pop);
        drop_d = arm_ok ? '0 : (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q <= '0;
            drop_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            drop_q <= drop_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop || ovw) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end
    nios2_oci_dct_ram #(.W(EW), .DEPTH(DEPTH)) u_ram (
        .clk(clk),
        .we_i(wr_en),
        .waddr_i(wr_ptr_q),
        .wdata_i({dct_count, dct_buffer}),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_data)
    );
    assign level = level_q;
    assign drop_cnt = drop_q;
    assign test_has_ended = state_q == ENDED;
endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// tb_nios2_oci_dct_capture: directed self-checking bench for the DCT capture buffer (DEPTH=16)
import nios2_oci_dct_pkg::*;
module tb_nios2_oci_dct_capture;
    logic clk, reset_n, arm, dct_valid, test_ending, rd_ready;
    logic [29:0] dct_buffer;
    logic [3:0] dct_count;
    logic rd_valid, test_has_ended;
    logic [33:0] rd_data;
    logic [4:0] level;
    logic [15:0] drop_cnt;
    int tests = 0;
    int fails = 0;

    nios2_oci_dct_capture dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
        .drop_cnt(drop_cnt), .test_has_ended(test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ent(input int c, input int b);
        return {30'b0, 4'(c), 30'(b)};
    endfunction

    task automatic put(input int c, input int b);
        dct_valid = 1'b1;
        dct_count = 4'(c);
        dct_buffer = 30'(b);
        tick();
        dct_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b0; dct_valid = 1'b0; test_ending = 1'b0;
        rd_ready = 1'b0; dct_buffer = '0; dct_count = '0;
        #2;
        chk("rst_level", level, 0);
        chk("rst_rvalid", rd_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ended", test_has_ended, 0);
        #10 reset_n = 1'b1;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_state", dut.state_q, CAPTURE);
        // three writes streamed straight through with the consumer always ready
        rd_ready = 1'b1;
        chk("pre_rvalid", rd_valid, 0);
        dct_valid = 1'b1; dct_count = 4'd1; dct_buffer = 30'h11;
        tick();
        chk("fwft_rvalid", rd_valid, 1);
        chk("fwft_d1", rd_data, ent(1, 'h11));
        dct_count = 4'd2; dct_buffer = 30'h22;
        tick();
        chk("stream_d2", rd_data, ent(2, 'h22));
        chk("stream_lvl", level, 1);
        dct_count = 4'd3; dct_buffer = 30'h33;
        tick();
        chk("stream_d3", rd_data, ent(3, 'h33));
        dct_valid = 1'b0;
        tick();
        chk("stream_empty", rd_valid, 0);
        chk("stream_lvl0", level, 0);
        rd_ready = 1'b0;
        put(0, 'h55);
        chk("zcnt_level", level, 0);
        chk("zcnt_drop", drop_cnt, 0);
        for (int i = 0; i < 18; i++) put(i % 15 + 1, 100 + i);
        chk("full_level", level, 16);
        chk("full_drop", drop_cnt, 2);
`ifdef NIOS2_OCI_DCT_WRAP_EN
        chk("full_head", rd_data, ent(3, 102));
`else
        chk("full_head", rd_data, ent(1, 100));
`endif
        rd_ready = 1'b1;
        put(5, 'h3ABC);
        rd_ready = 1'b0;
        chk("wrpop_level", level, 16);
        chk("wrpop_drop", drop_cnt, 2);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
`ifdef NIOS2_OCI_DCT_WRAP_EN
            if (i == 0) chk("drain_first", rd_data, ent(4, 103));
`else
            if (i == 0) chk("drain_first", rd_data, ent(2, 101));
`endif
            if (i == 15) chk("drain_last", rd_data, ent(5, 'h3ABC));
            tick();
        end
        rd_ready = 1'b0;
        chk("drain_level", level, 0);
        for (int i = 0; i < 5; i++) put(i + 1, 200 + i);
        chk("pre_flush_lvl", level, 5);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("flush_state", dut.state_q, FLUSH);
        chk("flush_head", rd_data, ent(1, 200));
        rd_ready = 1'b1;
        dct_valid = 1'b1; dct_count = 4'd7; dct_buffer = 30'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("flush_level", level, 5'(4 - i));
        end
        chk("flush_not_ended", test_has_ended, 0);
        tick();
        chk("ended", test_has_ended, 1);
        chk("ended_level", level, 0);
        dct_valid = 1'b0; rd_ready = 1'b0;
        arm = 1'b1; test_ending = 1'b1;
        tick();
        arm = 1'b0; test_ending = 1'b0;
        chk("prio_ended", test_has_ended, 1);
        chk("prio_drop", drop_cnt, 2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_ended", test_has_ended, 0);
        chk("rearm_drop", drop_cnt, 0);
        chk("rearm_state", dut.state_q, CAPTURE);
        for (int i = 0; i < 7; i++) put(1, 300 + i);
        chk("pre_rst_lvl", level, 7);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_rvalid", rd_valid, 0);
        chk("arst_state", dut.state_q, IDLE);
        #2 reset_n = 1'b1;
        put(1, 'h99);
        chk("idle_nowrite", level, 0);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("idle_to_ended", test_has_ended, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
